output_argmax: RTL and testbench
================================

Name: output_argmax

Overview:
- Consumer end of the second-layer accumulator interface.
- Captures each finished neuron sum on the `add_bias` pulse and adds that neuron's bias, fetched from an external bias ROM.
- Emits the biased logit and tracks the running maximum.
- After `NOUT` neurons, reports the winning class index (the MNIST digit) with a one-cycle done pulse.

Parameters:
- NWBITS, 16, weight/activation width.
- COUNT_BIT1, 10, first-layer accumulation growth bits.
- COUNT_BIT2, 8, second-layer accumulation growth bits.
- NOUT, 10, number of output neurons per frame.
- IDXW, 4, neuron index width; must satisfy 2^IDXW >= NOUT.
- NBBITS, 16, bias width (signed).
- BIAS_SHIFT, 0, left shift aligning bias to the sum's fixed-point scale; NBBITS+BIAS_SHIFT <= SUMW.
- Derived localparams: SUMW = 2*NWBITS+COUNT_BIT1+COUNT_BIT2 (50); LOGW = SUMW+1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- add_bias  input  1  one-cycle pulse; weighted_sum is final this cycle.
- weighted_sum  input  SUMW  signed neuron sum, valid while add_bias=1.
- frame_clear  input  1  synchronous abort of the current frame.
- bias_addr  output  IDXW  index of the neuron expected next; drives the combinational bias ROM.
- bias_data  input  NBBITS  signed bias for bias_addr, same-cycle valid.
- logit  output  LOGW  signed biased sum of the last accepted neuron.
- logit_valid  output  1  one-cycle pulse with each new logit.
- class_idx  output  IDXW  argmax index of the last completed frame.
- class_valid  output  1  one-cycle pulse when class_idx updates.
- busy  output  1  high when at least one neuron of the current frame has been accepted.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - bias_addr=0, logit=0, logit_valid=0, class_idx=0, class_valid=0, busy=0.
  - Internal max=0, max_idx=0, counter=0, first flag set.
- Counter: bias_addr equals the neuron counter (0..NOUT-1).
- Accept: on a cycle with add_bias=1 (and frame_clear=0, reset=0):
  - Combinational compute: logit_next = sext(weighted_sum, LOGW) + (sext(bias_data, LOGW) << BIAS_SHIFT). The result is exact; no saturation and no overflow are possible.
  - Registered at the next edge: logit<=logit_next and logit_valid<=1, so latency is 1 cycle.
  - Compare: if the first flag is set or logit_next > max (strict, signed), then max<=logit_next and max_idx<=counter. Ties keep the lower index.
  - Counter and state: first flag is cleared, busy<=1, counter increments.
- Frame complete: when accepting with counter==NOUT-1:
  - Same edge: class_idx<=final argmax, which includes this neuron's comparison.
  - class_valid<=1, logit_valid<=1.
  - counter<=0, first flag set, busy<=0.
- Pulse widths: logit_valid and class_valid are exactly one cycle; both deassert on the next edge unless a new accept occurs.
- Back-to-back: add_bias is legal every cycle; every pulse is accepted and there is no backpressure.
- frame_clear:
  - Returns counter, max, max_idx, busy and the first flag to their reset values.
  - Holds class_idx, logit and bias_addr-derived state unaffected except the counter.
  - Deasserts logit_valid and class_valid.
  - If frame_clear and add_bias coincide, clear wins and the sample is discarded.
- Reset mid-frame: all state returns to reset values and the partial frame is discarded. Reset has priority over frame_clear and add_bias.
- weighted_sum is ignored when add_bias=0.

Test Plan:
- Monotonic frame, bias all 0, BIAS_SHIFT=0: sums 0,1,...,9 on 10 pulses spaced 3 cycles apart.
  - 10 logit_valid pulses, logit equals each sum.
  - class_idx=9, class_valid high exactly on the cycle after the 10th pulse; busy low afterward.
- Bias dominance: all sums=100, bias[k]=k except bias[4]=50.
  - logit[4]=150; class_idx=4.
- Tie and negatives: sums all -1000, biases 0, back-to-back pulses.
  - class_idx=0 (the lower index wins ties).
  - Every logit=-1000, with 10 consecutive logit_valid cycles.
- Width extremes: sum=+(2^49-1), bias=+32767 with BIAS_SHIFT=0.
  - logit=2^49+32766 with no wrap.
  - A second frame with sum=-2^49, bias=-32768 gives logit=-(2^49)-32768.
- Abort: 5 pulses, then frame_clear coincident with the 6th pulse, then a full 10-pulse frame with a maximum at index 7.
  - No class_valid after the aborted 5; the 6th sample is dropped.
  - The following frame reports class_idx=7.
- Reset mid-frame: reset asserted after 3 pulses.
  - All outputs return to 0.
  - The next 10 pulses form a complete frame with bias_addr stepping 0..9.

Source files
------------

// File: rtl/output_argmax.sv
// Output-layer argmax: adds a per-neuron bias to each finished second-layer
// sum, emits the biased logit, tracks the running maximum and reports the
// winning class index once all NOUT neurons of a frame have arrived.
//
// Handshake: add_bias is a one-cycle strobe with no backpressure. Every
// cycle with add_bias=1 (and no reset/frame_clear) consumes weighted_sum and
// bias_data, and produces a one-cycle logit_valid pulse on the next edge.
module output_argmax #(
  parameter int NWBITS     = 16,
  parameter int COUNT_BIT1 = 10,
  parameter int COUNT_BIT2 = 8,
  parameter int NOUT       = 10,
  parameter int IDXW       = 4,
  parameter int NBBITS     = 16,
  parameter int BIAS_SHIFT = 0,
  localparam int SUMW      = 2*NWBITS + COUNT_BIT1 + COUNT_BIT2,
  localparam int LOGW      = SUMW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   add_bias,
  input  logic signed [SUMW-1:0] weighted_sum,
  input  logic                   frame_clear,
  output logic [IDXW-1:0]        bias_addr,
  input  logic signed [NBBITS-1:0] bias_data,
  output logic signed [LOGW-1:0] logit,
  output logic                   logit_valid,
  output logic [IDXW-1:0]        class_idx,
  output logic                   class_valid,
  output logic                   busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NOUT - 1);

  // Frame-tracking state.
  logic [IDXW-1:0]        counter;
  logic                   first;
  logic signed [LOGW-1:0] max_val;
  logic [IDXW-1:0]        max_idx;

  // Combinational datapath.
  logic signed [LOGW-1:0] sum_ext;
  logic signed [LOGW-1:0] bias_ext;
  logic signed [LOGW-1:0] logit_next;
  logic                   take_new;
  logic [IDXW-1:0]        best_idx;

  // The ROM is addressed by the index of the neuron expected next.
  assign bias_addr = counter;

  // Sign-extend both operands to LOGW so the add is exact, then compare to max.
  always_comb begin
    sum_ext    = {{(LOGW-SUMW){weighted_sum[SUMW-1]}}, weighted_sum};
    bias_ext   = {{(LOGW-NBBITS){bias_data[NBBITS-1]}}, bias_data};
    logit_next = sum_ext + (bias_ext <<< BIAS_SHIFT);
    // Strict compare so ties keep the earlier (lower) index.
    take_new   = first | (logit_next > max_val);
    best_idx   = take_new ? counter : max_idx;
  end

  // Frame state, logit register and the result pulses; reset beats clear beats accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter     <= '0;
      first       <= 1'b1;
      max_val     <= '0;
      max_idx     <= '0;
      logit       <= '0;
      logit_valid <= 1'b0;
      class_idx   <= '0;
      class_valid <= 1'b0;
      busy        <= 1'b0;
    end else if (frame_clear) begin
      // Abort the partial frame; the last logit and class stay visible.
      counter     <= '0;
      first       <= 1'b1;
      max_val     <= '0;
      max_idx     <= '0;
      logit_valid <= 1'b0;
      class_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      logit_valid <= add_bias;
      class_valid <= 1'b0;
      if (add_bias) begin
        logit <= logit_next;
        if (take_new) begin
          max_val <= logit_next;
          max_idx <= counter;
        end
        if (counter == LAST_IDX) begin
          // Final neuron: its own comparison is folded into best_idx.
          class_idx   <= best_idx;
          class_valid <= 1'b1;
          counter     <= '0;
          first       <= 1'b1;
          busy        <= 1'b0;
        end else begin
          counter <= counter + IDXW'(1);
          first   <= 1'b0;
          busy    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: inputs change on the falling edge and
// outputs are checked on the following falling edge, away from the rising edge.
module tb_output_argmax;

  localparam int SUMW = 50;
  localparam int LOGW = 51;
  localparam int IDXW = 4;

  logic                   clk;
  logic                   reset;
  logic                   add_bias;
  logic signed [SUMW-1:0] weighted_sum;
  logic                   frame_clear;
  logic [IDXW-1:0]        bias_addr;
  logic signed [15:0]     bias_data;
  logic signed [LOGW-1:0] logit;
  logic                   logit_valid;
  logic [IDXW-1:0]        class_idx;
  logic                   class_valid;
  logic                   busy;

  logic signed [15:0] bias_rom [0:15];

  int total;
  int bad;

  assign bias_data = bias_rom[bias_addr];

  output_argmax dut (
    .clk          (clk),
    .reset        (reset),
    .add_bias     (add_bias),
    .weighted_sum (weighted_sum),
    .frame_clear  (frame_clear),
    .bias_addr    (bias_addr),
    .bias_data    (bias_data),
    .logit        (logit),
    .logit_valid  (logit_valid),
    .class_idx    (class_idx),
    .class_valid  (class_valid),
    .busy         (busy)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs and advance to the next falling edge.
  task automatic step(input logic a, input logic signed [SUMW-1:0] s, input logic c);
    add_bias     = a;
    weighted_sum = s;
    frame_clear  = c;
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) bias_rom[i] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    reset = 1'b0;
    total += 6;
    if (bias_addr !== 4'd0) begin bad++; $display("FAIL reset_bias_addr got=%0d want=0", bias_addr); end
    if (logit !== '0) begin bad++; $display("FAIL reset_logit got=%0d want=0", logit); end
    if (logit_valid !== 1'b0) begin bad++; $display("FAIL reset_logit_valid got=%b want=0", logit_valid); end
    if (class_idx !== 4'd0) begin bad++; $display("FAIL reset_class_idx got=%0d want=0", class_idx); end
    if (class_valid !== 1'b0) begin bad++; $display("FAIL reset_class_valid got=%b want=0", class_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  // Sums 0..9, zero bias, pulses three cycles apart.
  task automatic test_monotonic();
    logic signed [LOGW-1:0] exp_l;
    clear_rom();
    for (int k = 0; k < 10; k++) begin
      total++;
      if (bias_addr !== 4'(k)) begin bad++; $display("FAIL mono_addr k=%0d got=%0d want=%0d", k, bias_addr, k); end
      step(1'b1, SUMW'(k), 1'b0);
      exp_l = LOGW'(k);
      total += 4;
      if (logit_valid !== 1'b1) begin bad++; $display("FAIL mono_lv k=%0d got=%b want=1", k, logit_valid); end
      if (logit !== exp_l) begin bad++; $display("FAIL mono_logit k=%0d got=%0d want=%0d", k, logit, exp_l); end
      if (class_valid !== (k == 9)) begin bad++; $display("FAIL mono_cv k=%0d got=%b want=%b", k, class_valid, k == 9); end
      if (busy !== (k != 9)) begin bad++; $display("FAIL mono_busy k=%0d got=%b want=%b", k, busy, k != 9); end
      step(1'b0, SUMW'(12345), 1'b0);
      total += 2;
      if (logit_valid !== 1'b0) begin bad++; $display("FAIL mono_lv_drop k=%0d got=%b want=0", k, logit_valid); end
      if (class_valid !== 1'b0) begin bad++; $display("FAIL mono_cv_drop k=%0d got=%b want=0", k, class_valid); end
      step(1'b0, '0, 1'b0);
    end
    total += 2;
    if (class_idx !== 4'd9) begin bad++; $display("FAIL mono_class got=%0d want=9", class_idx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mono_busy_end got=%b want=0", busy); end
  endtask

  // Equal sums of 100; bias k except bias[4]=50 makes neuron 4 win.
  task automatic test_bias_dominance();
    logic signed [LOGW-1:0] exp_l;
    clear_rom();
    for (int i = 0; i < 10; i++) bias_rom[i] = 16'(i);
    bias_rom[4] = 16'sd50;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, SUMW'(100), 1'b0);
      exp_l = (k == 4) ? LOGW'(150) : LOGW'(100 + k);
      total++;
      if (logit !== exp_l) begin bad++; $display("FAIL bias_logit k=%0d got=%0d want=%0d", k, logit, exp_l); end
    end
    total += 2;
    if (class_valid !== 1'b1) begin bad++; $display("FAIL bias_cv got=%b want=1", class_valid); end
    if (class_idx !== 4'd4) begin bad++; $display("FAIL bias_class got=%0d want=4", class_idx); end
    step(1'b0, '0, 1'b0);
  endtask

  // All sums -1000, back-to-back: ties resolve to index 0.
  task automatic test_back_to_back();
    logic signed [LOGW-1:0] exp_l;
    clear_rom();
    exp_l = -LOGW'(1000);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, -SUMW'(1000), 1'b0);
      total += 3;
      if (logit_valid !== 1'b1) begin bad++; $display("FAIL b2b_lv k=%0d got=%b want=1", k, logit_valid); end
      if (logit !== exp_l) begin bad++; $display("FAIL b2b_logit k=%0d got=%0d want=%0d", k, logit, exp_l); end
      if (class_valid !== (k == 9)) begin bad++; $display("FAIL b2b_cv k=%0d got=%b want=%b", k, class_valid, k == 9); end
    end
    total++;
    if (class_idx !== 4'd0) begin bad++; $display("FAIL b2b_class got=%0d want=0", class_idx); end
    step(1'b0, '0, 1'b0);
    total += 2;
    if (logit_valid !== 1'b0) begin bad++; $display("FAIL b2b_lv_end got=%b want=0", logit_valid); end
    if (class_valid !== 1'b0) begin bad++; $display("FAIL b2b_cv_end got=%b want=0", class_valid); end
  endtask

  // Largest positive and negative sum/bias combinations must not wrap.
  task automatic test_extremes();
    logic signed [SUMW-1:0] s;
    logic signed [LOGW-1:0] exp_l;
    clear_rom();
    bias_rom[0] = 16'sd32767;
    s = {1'b0, {(SUMW-1){1'b1}}};
    step(1'b1, s, 1'b0);
    exp_l = (LOGW'(1) <<< 49) + LOGW'(32766);
    total++;
    if (logit !== exp_l) begin bad++; $display("FAIL ext_pos got=%0d want=%0d", logit, exp_l); end
    for (int k = 1; k < 10; k++) step(1'b1, '0, 1'b0);
    total++;
    if (class_idx !== 4'd0) begin bad++; $display("FAIL ext_pos_class got=%0d want=0", class_idx); end
    bias_rom[0] = -16'sd32768;
    s = {1'b1, {(SUMW-1){1'b0}}};
    step(1'b1, s, 1'b0);
    exp_l = -(LOGW'(1) <<< 49) - LOGW'(32768);
    total++;
    if (logit !== exp_l) begin bad++; $display("FAIL ext_neg got=%0d want=%0d", logit, exp_l); end
    for (int k = 1; k < 10; k++) step(1'b1, '0, 1'b0);
    total++;
    if (class_idx !== 4'd1) begin bad++; $display("FAIL ext_neg_class got=%0d want=1", class_idx); end
    step(1'b0, '0, 1'b0);
  endtask

  // Five samples, clear coincident with the sixth, then a full frame peaking at 7.
  task automatic test_abort();
    clear_rom();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, SUMW'(50 - 10*k), 1'b0);
      total++;
      if (class_valid !== 1'b0) begin bad++; $display("FAIL abort_cv k=%0d got=%b want=0", k, class_valid); end
    end
    step(1'b1, SUMW'(999), 1'b1);
    total += 5;
    if (logit_valid !== 1'b0) begin bad++; $display("FAIL abort_lv got=%b want=0", logit_valid); end
    if (class_valid !== 1'b0) begin bad++; $display("FAIL abort_cv_clr got=%b want=0", class_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    if (bias_addr !== 4'd0) begin bad++; $display("FAIL abort_addr got=%0d want=0", bias_addr); end
    if (logit !== LOGW'(10)) begin bad++; $display("FAIL abort_logit_hold got=%0d want=10", logit); end
    for (int k = 0; k < 10; k++) begin
      step(1'b1, (k == 7) ? SUMW'(500) : SUMW'(10*k), 1'b0);
      total++;
      if (class_valid !== (k == 9)) begin bad++; $display("FAIL abort_frame_cv k=%0d got=%b want=%b", k, class_valid, k == 9); end
    end
    total++;
    if (class_idx !== 4'd7) begin bad++; $display("FAIL abort_class got=%0d want=7", class_idx); end
    step(1'b0, '0, 1'b0);
  endtask

  // Reset after three samples, then a clean frame with bias_addr stepping 0..9.
  task automatic test_reset_mid();
    clear_rom();
    for (int k = 0; k < 3; k++) step(1'b1, SUMW'(5 + k), 1'b0);
    reset = 1'b1;
    step(1'b1, SUMW'(77), 1'b0);
    reset = 1'b0;
    total += 6;
    if (bias_addr !== 4'd0) begin bad++; $display("FAIL rmid_addr got=%0d want=0", bias_addr); end
    if (logit !== '0) begin bad++; $display("FAIL rmid_logit got=%0d want=0", logit); end
    if (logit_valid !== 1'b0) begin bad++; $display("FAIL rmid_lv got=%b want=0", logit_valid); end
    if (class_idx !== 4'd0) begin bad++; $display("FAIL rmid_class got=%0d want=0", class_idx); end
    if (class_valid !== 1'b0) begin bad++; $display("FAIL rmid_cv got=%b want=0", class_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    for (int k = 0; k < 10; k++) begin
      total++;
      if (bias_addr !== 4'(k)) begin bad++; $display("FAIL rmid_step_addr k=%0d got=%0d want=%0d", k, bias_addr, k); end
      step(1'b1, (k == 2) ? SUMW'(900) : SUMW'(k), 1'b0);
    end
    total += 2;
    if (class_valid !== 1'b1) begin bad++; $display("FAIL rmid_frame_cv got=%b want=1", class_valid); end
    if (class_idx !== 4'd2) begin bad++; $display("FAIL rmid_frame_class got=%0d want=2", class_idx); end
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    add_bias     = 1'b0;
    weighted_sum = '0;
    frame_clear  = 1'b0;
    clear_rom();
    @(negedge clk);
    test_reset();
    test_monotonic();
    test_bias_dominance();
    test_back_to_back();
    test_extremes();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
